clk_div_gen: RTL and testbench

Synchronous clock-divider generator for the serial-link datapath. Consumes the master `clk16f` and produces the register-derived divided clocks `clk8f`, `clk4f`, `clk2f` and `clkf`, all phase-aligned to a common 16-cycle frame. It also provides a frame phase index, a frame-start strobe, per-clock glitch-free gating and a lock indication. The block is the source of the divided clocks that downstream blocks and their probadores check against `clk16f`.

---
 rtl/clk_div_gen_if.sv | 35 +++
 rtl/clk_div_gen.sv | 95 +++++++++
 tb/tb_clk_div_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// Divided-clock bundle for clk_div_gen.
// The master side (the generator) takes the enable mask and drives the clocks and frame status.
// The slave side is the view a downstream consumer of the clocks sees.
interface clk_div_gen_if;
    logic [3:0] enable_mask;  // bit3 clk8f, bit2 clk4f, bit1 clk2f, bit0 clkf
    logic       clk8f;
    logic       clk4f;
    logic       clk2f;
    logic       clkf;
    logic [3:0] phase;
    logic       frame_start;
    logic       locked;

    modport master (
        input  enable_mask,
        output clk8f,
        output clk4f,
        output clk2f,
        output clkf,
        output phase,
        output frame_start,
        output locked
    );

    modport slave (
        output enable_mask,
        input  clk8f,
        input  clk4f,
        input  clk2f,
        input  clkf,
        input  phase,
        input  frame_start,
        input  locked
    );
endinterface

// File: rtl/clk_div_gen.sv
// Clock-divider generator: derives clk8f/clk4f/clk2f/clkf from clk16f on a common
// 16-cycle frame, with frame phase, frame-start strobe, per-clock whole-frame
// gating and a sticky lock indication after LOCK_CYCLES complete frames.
module clk_div_gen #(
    parameter int unsigned LOCK_CYCLES = 8  // legal range 1..255
) (
    input  logic          clk16f,
    input  logic          reset,
    clk_div_gen_if.master bus
);

    localparam int unsigned FcntW = $clog2(LOCK_CYCLES + 1);
    localparam logic [FcntW-1:0] LockCnt  = FcntW'(LOCK_CYCLES);
    localparam logic [FcntW-1:0] LockLast = FcntW'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {StAcquire, StLocked} lock_st_e;

    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       en_q, en_d;
    logic [3:0]       clk_q, clk_d;      // bit3 clk8f .. bit0 clkf, same order as enable_mask
    logic             frame_start_q;
    logic             wrap;
    logic [FcntW-1:0] frame_cnt_q;
    logic             locked_q;
    lock_st_e         lock_st_q;

    // Next-state for the frame counter, the frame enables and the clock flops.
    always_comb begin
        cnt_d = cnt_q + 4'd1;
        wrap  = (cnt_q == 4'hF);
        // The mask is only taken on the 15->0 edge so a gate covers whole periods.
        en_d  = wrap ? bus.enable_mask : en_q;
        // Clock outputs are the next counter bits, so they and phase update together.
        clk_d = {cnt_d[0], cnt_d[1], cnt_d[2], cnt_d[3]} & en_d;
    end

    // Frame counter, active enables, clock output flops and frame-start strobe.
    always_ff @(posedge clk16f) begin
        if (reset) begin
            cnt_q         <= 4'd0;
            en_q          <= 4'b1111;
            clk_q         <= 4'b0000;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            clk_q         <= clk_d;
            frame_start_q <= wrap;
        end
    end

    // Lock FSM: counts completed frames (saturating) and sets the sticky lock flag.
    always_ff @(posedge clk16f) begin
        if (reset) begin
            lock_st_q   <= StAcquire;
            frame_cnt_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            if (wrap && (frame_cnt_q != LockCnt)) begin
                frame_cnt_q <= frame_cnt_q + FcntW'(1);
            end
            unique case (lock_st_q)
                StAcquire: begin
                    if (wrap && (frame_cnt_q == LockLast)) begin
                        lock_st_q <= StLocked;
                        locked_q  <= 1'b1;
                    end
                end
                StLocked: begin
                    locked_q <= 1'b1;
                end
            endcase
        end
    end

    // Every output comes straight from a flop.
    assign bus.clk8f       = clk_q[3];
    assign bus.clk4f       = clk_q[2];
    assign bus.clk2f       = clk_q[1];
    assign bus.clkf        = clk_q[0];
    assign bus.phase       = cnt_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;

    // A frame-start strobe can only coincide with phase 0.
    a_frame_start_phase0: assert property (
        @(posedge clk16f) disable iff (reset) frame_start_q |-> (cnt_q == 4'd0)
    );

    // clk8f can only be high on odd phases.
    a_clk8f_odd_phase: assert property (
        @(posedge clk16f) disable iff (reset) clk_q[3] |-> cnt_q[0]
    );

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: edge-count reference model plus directed literal checks.
module tb_clk_div_gen;

    logic       clk16f;
    logic       reset;
    logic [3:0] enable_mask;

    clk_div_gen_if bus0 ();
    clk_div_gen_if bus1 ();

    assign bus0.enable_mask = enable_mask;
    assign bus1.enable_mask = enable_mask;

    clk_div_gen #(.LOCK_CYCLES(8)) dut0 (
        .clk16f (clk16f),
        .reset  (reset),
        .bus    (bus0)
    );

    clk_div_gen #(.LOCK_CYCLES(1)) dut1 (
        .clk16f (clk16f),
        .reset  (reset),
        .bus    (bus1)
    );

    initial begin
        clk16f = 1'b0;
        forever #5 clk16f = ~clk16f;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: edge count since release and the mask governing the current frame.
    int         m_n     = 0;
    logic [3:0] m_en    = 4'b1111;
    bit         m_valid = 1'b0;

    always @(posedge clk16f) begin
        if (reset) begin
            m_n     = 0;
            m_en    = 4'b1111;
            m_valid = 1'b1;
        end else begin
            m_n = m_n + 1;
            if (m_n % 16 == 0) m_en = enable_mask;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, m_n);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk16f) begin
        if (m_valid) begin
            check("phase",       32'(bus0.phase),       32'(m_n % 16));
            check("clk8f",       32'(bus0.clk8f),       32'(((m_n / 1) % 2) & int'(m_en[3])));
            check("clk4f",       32'(bus0.clk4f),       32'(((m_n / 2) % 2) & int'(m_en[2])));
            check("clk2f",       32'(bus0.clk2f),       32'(((m_n / 4) % 2) & int'(m_en[1])));
            check("clkf",        32'(bus0.clkf),        32'(((m_n / 8) % 2) & int'(m_en[0])));
            check("frame_start", 32'(bus0.frame_start), 32'((m_n > 0) && (m_n % 16 == 0)));
            check("locked",      32'(bus0.locked),      32'(m_n >= 16 * 8));
            check("phase_l1",    32'(bus1.phase),       32'(m_n % 16));
            check("fs_l1",       32'(bus1.frame_start), 32'((m_n > 0) && (m_n % 16 == 0)));
            check("locked_l1",   32'(bus1.locked),      32'(m_n >= 16));
        end
    end

    // Advance to the negedge following edge `target`; optionally randomize the mask.
    task automatic run_to(input int target, input bit rnd);
        int guard;
        guard = 0;
        while (m_n < target) begin
            @(negedge clk16f);
            if (rnd && ($urandom_range(3) == 0)) enable_mask = 4'($urandom);
            guard++;
            if (guard > 1000) begin
                $display("FAIL run_to: edge %0d required %0d", m_n, target);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
                $fatal(1);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable_mask = 4'hF;
        repeat (3) @(negedge clk16f);
        check("rst_phase",  32'(bus0.phase),  32'd0);
        check("rst_clk8f",  32'(bus0.clk8f),  32'd0);
        check("rst_clkf",   32'(bus0.clkf),   32'd0);
        check("rst_locked", 32'(bus0.locked), 32'd0);
        reset = 1'b0;

        run_to(1, 1'b0);   check("lit_clk8f_e1", 32'(bus0.clk8f), 32'd1);
        run_to(8, 1'b0);   check("lit_clkf_e8",  32'(bus0.clkf),  32'd1);
        run_to(15, 1'b0);  check("lit_lock1_e15", 32'(bus1.locked), 32'd0);
        run_to(16, 1'b0);
        check("lit_clkf_e16",  32'(bus0.clkf),        32'd0);
        check("lit_fs_e16",    32'(bus0.frame_start), 32'd1);
        check("lit_lock1_e16", 32'(bus1.locked),      32'd1);
        check("lit_fs1_e16",   32'(bus1.frame_start), 32'd1);
        run_to(17, 1'b0);  check("lit_fs_e17", 32'(bus0.frame_start), 32'd0);

        // Mask pulse away from a wrap has no effect.
        run_to(18, 1'b0);  enable_mask = 4'h0;
        run_to(24, 1'b0);  check("lit_clkf_e24",  32'(bus0.clkf),  32'd1);
        run_to(25, 1'b0);  check("lit_clk8f_e25", 32'(bus0.clk8f), 32'd1);
        run_to(28, 1'b0);  enable_mask = 4'hF;

        // Gate clkf: set mid-frame, honoured from edge 48 to 64.
        run_to(37, 1'b0);  enable_mask = 4'b1110;
        run_to(40, 1'b0);  check("lit_clkf_e40", 32'(bus0.clkf), 32'd1);
        run_to(50, 1'b0);  enable_mask = 4'hF;
        run_to(56, 1'b0);  check("lit_clkf_e56_gated", 32'(bus0.clkf), 32'd0);
        run_to(57, 1'b0);  check("lit_clk8f_e57", 32'(bus0.clk8f), 32'd1);
        run_to(60, 1'b0);  check("lit_clk2f_e60", 32'(bus0.clk2f), 32'd1);
        run_to(72, 1'b0);  check("lit_clkf_e72", 32'(bus0.clkf), 32'd1);

        // Random masks through the lock point.
        run_to(127, 1'b1); check("lit_locked_e127", 32'(bus0.locked), 32'd0);
        run_to(128, 1'b1); check("lit_locked_e128", 32'(bus0.locked), 32'd1);
        run_to(150, 1'b1);

        // Restart, then a one-cycle reset at edge 70.
        reset = 1'b1;
        @(negedge clk16f);
        reset = 1'b0;
        run_to(70, 1'b1);
        reset = 1'b1;
        @(negedge clk16f);
        check("mid_rst_phase",  32'(bus0.phase),  32'd0);
        check("mid_rst_clk8f",  32'(bus0.clk8f),  32'd0);
        check("mid_rst_clk4f",  32'(bus0.clk4f),  32'd0);
        check("mid_rst_locked", 32'(bus0.locked), 32'd0);
        reset = 1'b0;
        run_to(127, 1'b1); check("lit_relock_e127", 32'(bus0.locked), 32'd0);
        run_to(128, 1'b1); check("lit_relock_e128", 32'(bus0.locked), 32'd1);
        run_to(140, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
